hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage pipeline. It tracks in-flight destination registers through E, M and W using Tuse/Tnew bookkeeping. It generates the D-stage forwarding selects that drive the `mux8` operand selectors and the D-stage stall/bubble. It also owns the multiply/divide busy counter, replacing ad-hoc combinational hazard logic with a generalised N-source, latency-configurable unit.

---
 rtl/hazard_ctrl_pkg.sv | 42 ++++
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl_hz_match.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 72 +++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard/forwarding controller.
// Latency: none (types and constants only).
// Backpressure: n/a.
//
// Holds the mux8 forwarding-select codes, result-kind codes, the Tuse
// "unused" marker, the per-stage record and a saturating Tnew decrement.
package pipe_pkg;

    // mux8 operand-select encoding
    localparam logic [2:0] FWD_REG  = 3'd0;
    localparam logic [2:0] FWD_PC8E = 3'd1;
    localparam logic [2:0] FWD_ALUM = 3'd2;
    localparam logic [2:0] FWD_PC8M = 3'd3;
    localparam logic [2:0] FWD_RESW = 3'd4;

    // Result kind of a producing instruction
    localparam logic [1:0] KIND_PC8 = 2'd0;
    localparam logic [1:0] KIND_ALU = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Which stage supplied the producer for a source operand
    typedef enum logic [1:0] {
        ST_E    = 2'd0,
        ST_M    = 2'd1,
        ST_W    = 2'd2,
        ST_NONE = 2'd3
    } stage_id_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] kind;
    } stage_rec_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage hazard query bundle: source operands/Tuse, D record, mult/div flags, results.
// Latency: none (wires only).
// Backpressure: stall is the only backpressure; master holds D inputs while it is high.
//
// master = pipeline front end (drives D-stage info), slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int NSRC = 2
);
    logic [NSRC*5-1:0] srcaddrd;
    logic [NSRC*2-1:0] tused;
    logic [4:0]        dstd;
    logic [1:0]        tnewd;
    logic [1:0]        kindd;
    logic              mdstartd;
    logic              mdisdivd;
    logic              mdused;
    logic              stall;
    logic [NSRC*3-1:0] fwdsel;
    logic              mdbusy;

    modport master (
        output srcaddrd, tused, dstd, tnewd, kindd, mdstartd, mdisdivd, mdused,
        input  stall, fwdsel, mdbusy
    );

    modport slave (
        input  srcaddrd, tused, dstd, tnewd, kindd, mdstartd, mdisdivd, mdused,
        output stall, fwdsel, mdbusy
    );
endinterface

// File: rtl/hazard_ctrl_hz_match.sv
// Per-operand hazard check: finds youngest E/M/W producer, derives stall and mux8 select.
// Latency: purely combinational.
// Backpressure: raises stall when the producer's Tnew exceeds the operand's Tuse.
//
// Ports: e_rec/m_rec/w_rec stage records, addr/tuse of one D operand,
//        stall and fwdsel for that operand.
module hz_match
    import pipe_pkg::*;
(
    input  stage_rec_t e_rec,
    input  stage_rec_t m_rec,
    input  stage_rec_t w_rec,
    input  logic [4:0] addr,
    input  logic [1:0] tuse,
    output logic       stall,
    output logic [2:0] fwdsel
);
    logic       active;
    stage_rec_t prod;
    stage_id_t  src;

    // $0 and unused operands never match anything
    assign active = (addr != 5'd0) && (tuse != TUSE_NONE);

    always_comb begin
        prod = '0;
        src  = ST_NONE;
        if (active && e_rec.valid && e_rec.dst == addr) begin
            prod = e_rec;
            src  = ST_E;
        end else if (active && m_rec.valid && m_rec.dst == addr) begin
            prod = m_rec;
            src  = ST_M;
        end else if (active && w_rec.valid && w_rec.dst == addr) begin
            prod = w_rec;
            src  = ST_W;
        end
    end

    always_comb begin
        stall  = 1'b0;
        fwdsel = FWD_REG;
        if (prod.valid) begin
            stall = (prod.tnew > tuse);
            // Not ready yet but within Tuse: read the regfile now, a later
            // stage will forward once the value exists.
            if (prod.tnew == 2'd0) begin
                case (src)
                    ST_E: if (prod.kind == KIND_PC8) fwdsel = FWD_PC8E;
                    ST_M: begin
                        if (prod.kind == KIND_PC8)      fwdsel = FWD_PC8M;
                        else if (prod.kind == KIND_ALU) fwdsel = FWD_ALUM;
                    end
                    ST_W:    fwdsel = FWD_RESW;
                    default: fwdsel = FWD_REG;
                endcase
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: E/M/W Tnew tracking, D-stage stall + mux8 selects, mult/div busy.
// Latency: stall/fwdsel combinational from D inputs; records and counter update on clk rise.
// Backpressure: stall freezes F/D and bubbles E; mult/div users stall while the unit is busy.
//
// Ports: clk, reset (sync, active-low), hz (slave side of hazard_ctrl_if).
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT);

    stage_rec_t    e_rec, m_rec, w_rec;
    stage_rec_t    d_rec;
    logic [CW-1:0] md_cnt;
    logic [NSRC-1:0] src_stall;
    logic          md_busy;
    logic          stall_all;

    assign d_rec = '{valid: (hz.dstd != 5'd0), dst: hz.dstd,
                     tnew: hz.tnewd, kind: hz.kindd};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hz_match u_match (
            .e_rec  (e_rec),
            .m_rec  (m_rec),
            .w_rec  (w_rec),
            .addr   (hz.srcaddrd[5*i +: 5]),
            .tuse   (hz.tused[2*i +: 2]),
            .stall  (src_stall[i]),
            .fwdsel (hz.fwdsel[3*i +: 3])
        );
    end

    assign md_busy   = (md_cnt != '0);
    assign stall_all = (|src_stall) | (hz.mdused & md_busy);
    assign hz.stall  = stall_all;
    assign hz.mdbusy = md_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_rec  <= '0;
            m_rec  <= '0;
            w_rec  <= '0;
            md_cnt <= '0;
        end else begin
            // Tnew is counted down on every stage move; a result reaching W
            // is therefore always ready (Tnew 0).
            w_rec      <= m_rec;
            w_rec.tnew <= tnew_dec(m_rec.tnew);
            m_rec      <= e_rec;
            m_rec.tnew <= tnew_dec(e_rec.tnew);
            e_rec      <= stall_all ? '0 : d_rec;

            // A stalled issue must not load, or the retry would load twice.
            if (hz.mdstartd && !stall_all)
                md_cnt <= hz.mdisdivd ? DIV_LD : MULT_LD;
            else if (md_busy)
                md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.NSRC(2)) hif ();

    hazard_ctrl #(.NSRC(2), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0] s0, s1;
        logic [1:0] t0, t1;
        logic [4:0] dst;
        logic [1:0] tnew, kind;
        logic       mds, mdd, mdu;
    } ins_t;

    function automatic ins_t mk(input int s0, s1, t0, t1, dst, tnew, kind, mds, mdd, mdu);
        ins_t r;
        r.s0 = 5'(s0); r.s1 = 5'(s1); r.t0 = 2'(t0); r.t1 = 2'(t1);
        r.dst = 5'(dst); r.tnew = 2'(tnew); r.kind = 2'(kind);
        r.mds = 1'(mds); r.mdd = 1'(mdd); r.mdu = 1'(mdu);
        return r;
    endfunction

    task automatic drive(input ins_t in);
        hif.srcaddrd = {in.s1, in.s0};
        hif.tused    = {in.t1, in.t0};
        hif.dstd     = in.dst;
        hif.tnewd    = in.tnew;
        hif.kindd    = in.kind;
        hif.mdstartd = in.mds;
        hif.mdisdivd = in.mdd;
        hif.mdused   = in.mdu;
    endtask

    // ---------------- reference model ----------------
    // Entries indexed by age after leaving D (0=E, 1=M, 2=W); readiness is
    // the issue-time Tnew minus age, floored at 0.
    int m_valid[3], m_dst[3], m_tnew[3], m_kind[3];
    int cyc = 0;
    int busy_until = 0;

    function automatic void model_src(input int addr, input int tuse, output int st, output int fw);
        st = 0;
        fw = 0;
        if (addr == 0 || tuse == 3) return;
        for (int a = 0; a < 3; a++) begin
            if (m_valid[a] != 0 && m_dst[a] == addr) begin
                int rdy;
                rdy = m_tnew[a] - a;
                if (rdy < 0) rdy = 0;
                st = (rdy > tuse) ? 1 : 0;
                if (rdy == 0) begin
                    if (a == 0)      fw = (m_kind[a] == 0) ? 1 : 0;
                    else if (a == 1) fw = (m_kind[a] == 0) ? 3 : (m_kind[a] == 1) ? 2 : 0;
                    else             fw = 4;
                end
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int s0, f0, s1, f1, est, ebusy;
            model_src(int'(hif.srcaddrd[4:0]), int'(hif.tused[1:0]), s0, f0);
            model_src(int'(hif.srcaddrd[9:5]), int'(hif.tused[3:2]), s1, f1);
            ebusy = (cyc < busy_until) ? 1 : 0;
            est = (s0 != 0 || s1 != 0 || (hif.mdused && ebusy != 0)) ? 1 : 0;
            chk("m_stall",  32'(hif.stall),       32'(est));
            chk("m_fwd0",   32'(hif.fwdsel[2:0]), 32'(f0));
            chk("m_fwd1",   32'(hif.fwdsel[5:3]), 32'(f1));
            chk("m_mdbusy", 32'(hif.mdbusy),      32'(ebusy));
            if (!reset) begin
                for (int a = 0; a < 3; a++) m_valid[a] = 0;
                busy_until = 0;
            end else begin
                for (int a = 2; a > 0; a--) begin
                    m_valid[a] = m_valid[a-1]; m_dst[a] = m_dst[a-1];
                    m_tnew[a]  = m_tnew[a-1];  m_kind[a] = m_kind[a-1];
                end
                m_valid[0] = (est == 0 && hif.dstd != 0) ? 1 : 0;
                m_dst[0]   = int'(hif.dstd);
                m_tnew[0]  = int'(hif.tnewd);
                m_kind[0]  = int'(hif.kindd);
                if (hif.mdstartd && est == 0)
                    busy_until = cyc + 1 + (hif.mdisdivd ? DIV_LAT : MULT_LAT);
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1. Holds the instruction in D while stall is high,
    // counts stall cycles, then checks the selects on the issuing cycle.
    task automatic issue(input string nm, input ins_t in, input int exp_st,
                         input int f0, input int f1);
        int nst;
        nst = 0;
        drive(in);
        forever begin
            #2;
            if (hif.stall !== 1'b1) break;
            nst++;
            if (nst > 40) begin
                chk({nm, "_timeout"}, 32'(nst), 32'(exp_st));
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_nstall"}, 32'(nst), 32'(exp_st));
        chk({nm, "_fwd0"}, 32'(hif.fwdsel[2:0]), 32'(f0));
        chk({nm, "_fwd1"}, 32'(hif.fwdsel[5:3]), 32'(f1));
        @(posedge clk); #1;
    endtask

    ins_t nop, mflo;

    task automatic drain();
        for (int i = 0; i < 3; i++) issue("drain", nop, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        mflo = mk(0, 0, 3, 3, 8, 1, 1, 0, 0, 1);
        for (int a = 0; a < 3; a++) begin
            m_valid[a] = 0; m_dst[a] = 0; m_tnew[a] = 0; m_kind[a] = 0;
        end
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",  32'(hif.stall),  32'd0);
        chk("rst_fwd",    32'(hif.fwdsel), 32'd0);
        chk("rst_mdbusy", 32'(hif.mdbusy), 32'd0);
        started = 1'b1;
        reset   = 1'b1;

        // ALU -> branch, tuse 0: one stall then ALUOUTM
        issue("addu1", mk(0, 0, 3, 3, 1, 1, 1, 0, 0, 0), 0, 0, 0);
        issue("beq1",  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 2, 0);
        drain();
        // ALU -> consumer with tuse 1: no stall, regfile select
        issue("addu1b", mk(0, 0, 3, 3, 1, 1, 1, 0, 0, 0), 0, 0, 0);
        issue("use1t1", mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        drain();
        // Load -> branch: two stalls then RESULTW
        issue("lw2",  mk(0, 0, 3, 3, 2, 2, 2, 0, 0, 0), 0, 0, 0);
        issue("beq2", mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0), 2, 4, 0);
        drain();
        // jal -> jr $31, then another jr one instruction later
        issue("jal",  mk(0, 0, 3, 3, 31, 0, 0, 0, 0, 0), 0, 0, 0);
        issue("jr_e", mk(31, 0, 0, 3, 0, 0, 0, 0, 0, 0), 0, 1, 0);
        issue("jr_m", mk(31, 0, 0, 3, 0, 0, 0, 0, 0, 0), 0, 3, 0);
        drain();
        // $0 never hazards
        issue("addu0", mk(0, 0, 3, 3, 0, 1, 1, 0, 0, 0), 0, 0, 0);
        issue("beq0",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        drain();
        // Youngest producer wins
        issue("addu4a", mk(0, 0, 3, 3, 4, 1, 1, 0, 0, 0), 0, 0, 0);
        issue("addu4b", mk(0, 0, 3, 3, 4, 1, 1, 0, 0, 0), 0, 0, 0);
        issue("use4_e", mk(4, 0, 1, 3, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        issue("use4_m", mk(4, 0, 1, 3, 0, 0, 0, 0, 0, 0), 0, 2, 0);
        issue("use4_w", mk(4, 0, 1, 3, 0, 0, 0, 0, 0, 0), 0, 4, 0);
        drain();
        // mult then mflo: 5 stall cycles
        issue("mult", mk(0, 0, 3, 3, 0, 0, 0, 1, 0, 1), 0, 0, 0);
        issue("mflo_m", mflo, MULT_LAT, 0, 0);
        drain();
        chk("mdbusy_after_mult", 32'(hif.mdbusy), 32'd0);
        // div then mflo: 10 stall cycles
        issue("div", mk(0, 0, 3, 3, 0, 0, 0, 1, 1, 1), 0, 0, 0);
        issue("mflo_d", mflo, DIV_LAT, 0, 0);
        drain();
        // Reset in the second stall cycle of a mult wait
        drive(mk(0, 0, 3, 3, 0, 0, 0, 1, 0, 1));
        @(posedge clk); #1;
        drive(mflo);
        #2 chk("rst_mid_st1", 32'(hif.stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #2 chk("rst_mid_st2", 32'(hif.stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("rst_mid_stall",  32'(hif.stall),  32'd0);
        chk("rst_mid_mdbusy", 32'(hif.mdbusy), 32'd0);
        @(posedge clk); #1;
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
